// File: rtl/rng_arb_pkg.sv
// Shared types and constants for the random-generator arbiter.
// Holds the FSM encoding, generator width, default timeout and bench seed.
package rng_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } arb_state_t;

   localparam int RNG_W = 16;
   localparam int TIMEOUT_DEF = 15;
   localparam logic [RNG_W-1:0] RNG_SEED = 16'h0005;

   // Index of the set bit in a one-hot vector of up to 8 bits.
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) r = r | 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit after ptr (mod N).
// Ports: req, ptr in; win (one-hot), valid out. Purely combinational.
module rr_priority_pick
   import rng_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic          valid
);

   localparam logic [PW:0] NV = (PW+1)'(N);

   logic [PW:0] sum;

   // Scan ptr+1 .. ptr+N; one conditional subtract keeps the
   // index in range for non-power-of-two N.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      sum   = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= NV) sum = sum - NV;
         if (!valid && req[sum[PW-1:0]]) begin
            win[sum[PW-1:0]] = 1'b1;
            valid            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR generator among NUM_REQ requesters.
// Ports: clock, rst (sync, high); req/gnt/rsp_valid per requester;
// rsp_data, busy; rng_en/rng_done/rng_data to the generator;
// err only when RNG_ARB_TIMEOUT_EN is defined (WAIT timeout abort).
module rng_arbiter
   import rng_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = RNG_W,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clock,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] rsp_valid,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               busy,
   output logic               rng_en,
   input  logic               rng_done,
   input  logic [DATA_W-1:0]  rng_data
`ifdef RNG_ARB_TIMEOUT_EN
   ,
   output logic               err
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("rng_arbiter: NUM_REQ must be 2..8, TIMEOUT >= 1");
   end

   arb_state_t         state;
   logic [PW-1:0]      ptr;
   logic [NUM_REQ-1:0] win_oh;
   logic               win_vld;
   logic [PW-1:0]      gnt_idx;

   rr_priority_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .win   (win_oh),
      .valid (win_vld)
   );

   assign gnt_idx = PW'(oh2idx(8'(gnt)));

`ifdef RNG_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] tcnt;
`endif

   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rng_en    <= 1'b0;
         busy      <= 1'b0;
         ptr       <= PW'(NUM_REQ - 1);
`ifdef RNG_ARB_TIMEOUT_EN
         tcnt      <= '0;
         err       <= 1'b0;
`endif
      end else begin
         rng_en    <= 1'b0;
         rsp_valid <= '0;
`ifdef RNG_ARB_TIMEOUT_EN
         err       <= 1'b0;
`endif
         unique case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  gnt    <= win_oh;
                  rng_en <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               // generator latches en_rng here and drops its done
               state <= ST_WAIT;
`ifdef RNG_ARB_TIMEOUT_EN
               tcnt  <= '0;
`endif
            end
            ST_WAIT: begin
               if (rng_done) begin
                  rsp_data  <= rng_data;
                  rsp_valid <= gnt;
                  gnt       <= '0;
                  ptr       <= gnt_idx;
                  state     <= ST_DELIVER;
`ifdef RNG_ARB_TIMEOUT_EN
               end else if (tcnt == TLAST) begin
                  err   <= 1'b1;
                  gnt   <= '0;
                  ptr   <= gnt_idx;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
`endif
               end
            end
            ST_DELIVER: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
